// File: rtl/fifo_mux_pkg.sv
// Shared spmv kernel constants: narrow/wide beat widths and packer lane indexing.
package fifo_mux_pkg;
    localparam int DATA_IN_WIDTH  = 64;
    localparam int DATA_OUT_WIDTH = 256;
    localparam int RATIO          = DATA_OUT_WIDTH / DATA_IN_WIDTH;

    function automatic int lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int LANE_W = lane_w(RATIO);
endpackage

// File: rtl/Fifo.sv
// First-word-fall-through FIFO of 2^DEPTH words with a registered fill counter.
module Fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [DEPTH:0]   count_o
);
    localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};

    logic [WIDTH-1:0] mem [2**DEPTH];
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH:0]   count_q, count_d;
    logic             do_wr, do_rd;

    assign full_o    = (count_q == CAP);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem[rd_ptr_q];

    // Full refuses writes even if a pop happens this cycle.
    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + DEPTH'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + DEPTH'(1);
        if (do_wr && !do_rd) count_d = count_q + (DEPTH+1)'(1);
        else if (!do_wr && do_rd) count_d = count_q - (DEPTH+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/data_pack.sv
// Packs narrow beats into wide words, lane 0 in the LSBs; flush emits a zero-padded partial word.
module data_pack #(
    parameter int IN_W  = fifo_mux_pkg::DATA_IN_WIDTH,
    parameter int OUT_W = fifo_mux_pkg::DATA_OUT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             flush_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [OUT_W-1:0] out_data_o
);
    localparam int             NLANE = OUT_W / IN_W;
    localparam int             LW    = fifo_mux_pkg::lane_w(NLANE);
    localparam logic [LW-1:0]  LAST  = LW'(NLANE - 1);

    logic [LW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] stage_q, stage_d, word;
    logic             accept, push;

    assign in_ready_o = out_ready_i;
    assign accept     = in_valid_i && out_ready_i;

    always_comb begin
        word = stage_q;
        for (int l = 0; l < NLANE; l++)
            if (accept && cnt_q == LW'(l)) word[l*IN_W +: IN_W] = in_data_i;
    end

    // A beat arriving with flush rides along in the flushed word.
    assign push = out_ready_i &&
                  ((accept && cnt_q == LAST) || (flush_i && (accept || cnt_q != '0)));

    always_comb begin
        cnt_d   = cnt_q;
        stage_d = stage_q;
        if (push) begin
            cnt_d   = '0;
            stage_d = '0;
        end else if (accept) begin
            cnt_d   = cnt_q + LW'(1);
            stage_d = word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    assign out_valid_o = push;
    assign out_data_o  = word;
endmodule

// File: rtl/fifo_mux.sv
// Narrow-to-wide width converter: beat packer feeding a FWFT FIFO with water-mark flags.
module fifo_mux #(
    parameter int DATA_IN_WIDTH  = fifo_mux_pkg::DATA_IN_WIDTH,
    parameter int DATA_OUT_WIDTH = fifo_mux_pkg::DATA_OUT_WIDTH,
    parameter int DEPTH          = 4,
    parameter int MIN_THER       = 1,
    parameter int MAX_THER       = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    input  logic                      flush,
    input  logic                      rd_en,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      empty,
    output logic                      full,
    output logic                      needdata,
    output logic                      noneeddata,
    output logic [DEPTH:0]            fill_level
);
    localparam logic [DEPTH:0] MIN_L = (DEPTH+1)'(MIN_THER);
    localparam logic [DEPTH:0] MAX_L = (DEPTH+1)'(MAX_THER);

    logic                      beat_rdy, pack_vld;
    logic [DATA_OUT_WIDTH-1:0] pack_data;

    data_pack #(.IN_W(DATA_IN_WIDTH), .OUT_W(DATA_OUT_WIDTH)) u_pack (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (wr_en),
        .in_ready_o  (beat_rdy),
        .in_data_i   (data_in),
        .flush_i     (flush),
        .out_ready_i (!full),
        .out_valid_o (pack_vld),
        .out_data_o  (pack_data)
    );

    Fifo #(.WIDTH(DATA_OUT_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (pack_vld && beat_rdy),
        .wr_data_i (pack_data),
        .rd_en_i   (rd_en),
        .rd_data_o (data_out),
        .empty_o   (empty),
        .full_o    (full),
        .count_o   (fill_level)
    );

    assign needdata   = (fill_level <= MIN_L);
    assign noneeddata = (fill_level >= MAX_L);
endmodule

// File: tb/tb_fifo_mux.sv
// Scoreboard bench for fifo_mux: expected wide words queued as beats are driven, checked on pop.
module tb_fifo_mux;
    logic         clk = 1'b0;
    logic         rst, wr_en, flush, rd_en;
    logic [63:0]  data_in;
    logic [255:0] data_out;
    logic         empty, full, needdata, noneeddata;
    logic [4:0]   fill_level;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [255:0] exp_q[$];
    int           mcnt, mfill;
    logic [255:0] mstage;

    always #5 clk = ~clk;

    fifo_mux dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .flush(flush),
        .rd_en(rd_en), .data_out(data_out), .empty(empty), .full(full),
        .needdata(needdata), .noneeddata(noneeddata), .fill_level(fill_level)
    );

    // One clock: drive inputs, advance the reference model, compare any popped word.
    task automatic cycle(input logic w, input logic [63:0] d, input logic f, input logic r);
        logic [255:0] word, exp;
        bit fullm, acc, push, pop;
        wr_en = w; data_in = d; flush = f; rd_en = r;
        #3;
        fullm = (mfill == 16);
        acc   = w && !fullm;
        pop   = r && (mfill > 0);
        word  = mstage;
        if (acc) word[mcnt*64 +: 64] = d;
        push  = !fullm && ((acc && mcnt == 3) || (f && (acc || mcnt != 0)));
        if (pop) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (data_out !== exp) begin
                n_fail++;
                $display("FAIL pop_data: got %h expected %h", data_out, exp);
            end
        end
        if (push) begin
            exp_q.push_back(word); mcnt = 0; mstage = '0;
        end else if (acc) begin
            mcnt++; mstage = word;
        end
        mfill += int'(push) - int'(pop);
        @(posedge clk); #1;
    endtask

    // Reset with every other input active to show they are ignored.
    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b1; flush = 1'b1; rd_en = 1'b1; data_in = '1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0; flush = 1'b0; rd_en = 1'b0; data_in = '0;
        mcnt = 0; mstage = '0; mfill = 0; exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (needdata !== 1'b1)  begin n_fail++; $display("FAIL reset_needdata: got %b expected 1", needdata); end
        n_checks++; if (noneeddata !== 1'b0) begin n_fail++; $display("FAIL reset_noneeddata: got %b expected 0", noneeddata); end
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
    endtask

    task automatic test_basic();
        logic [255:0] w;
        w = {64'h44, 64'h33, 64'h22, 64'h11};
        cycle(1, 64'h11, 0, 0); cycle(1, 64'h22, 0, 0);
        cycle(1, 64'h33, 0, 0); cycle(1, 64'h44, 0, 0);
        n_checks++; if (empty !== 1'b0)      begin n_fail++; $display("FAIL basic_empty: got %b expected 0", empty); end
        n_checks++; if (fill_level !== 5'd1) begin n_fail++; $display("FAIL basic_fill: got %0d expected 1", fill_level); end
        n_checks++; if (data_out !== w)      begin n_fail++; $display("FAIL basic_word: got %h expected %h", data_out, w); end
        n_checks++; if (needdata !== 1'b1)   begin n_fail++; $display("FAIL basic_needdata: got %b expected 1", needdata); end
        cycle(0, 0, 0, 1);
        n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL basic_drain: got %b expected 1", empty); end
        cycle(0, 0, 0, 1);
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL basic_rd_empty: got %0d expected 0", fill_level); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 64; i++) begin
            cycle(1, 64'hA000 + 64'(i), 0, 0);
            if (i == 43) begin
                n_checks++; if (noneeddata !== 1'b0) begin n_fail++; $display("FAIL full_nond11: got %b expected 0", noneeddata); end
            end
            if (i == 47) begin
                n_checks++; if (noneeddata !== 1'b1) begin n_fail++; $display("FAIL full_nond12: got %b expected 1", noneeddata); end
                n_checks++; if (full !== 1'b0)       begin n_fail++; $display("FAIL full_early: got %b expected 0", full); end
            end
        end
        n_checks++; if (full !== 1'b1)       begin n_fail++; $display("FAIL full_flag: got %b expected 1", full); end
        n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL full_fill: got %0d expected 16", fill_level); end
        cycle(1, 64'hDEAD, 0, 0);
        n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL full_drop: got %0d expected 16", fill_level); end
        // Beat and pop together while full: pop happens, beat refused.
        cycle(1, 64'hBEEF, 0, 1);
        n_checks++; if (fill_level !== 5'd15) begin n_fail++; $display("FAIL full_pop: got %0d expected 15", fill_level); end
        n_checks++; if (full !== 1'b0)        begin n_fail++; $display("FAIL full_release: got %b expected 0", full); end
        for (int i = 0; i < 15; i++) cycle(0, 0, 0, 1);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b expected 1", empty); end
        for (int i = 0; i < 4; i++) cycle(1, 64'hC0 + 64'(i), 0, 0);
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_flush();
        logic [255:0] w;
        w = {64'h0, 64'h0, 64'hB, 64'hA};
        cycle(1, 64'hA, 0, 0); cycle(1, 64'hB, 0, 0); cycle(0, 0, 1, 0);
        n_checks++; if (fill_level !== 5'd1) begin n_fail++; $display("FAIL flush_fill: got %0d expected 1", fill_level); end
        n_checks++; if (data_out !== w)      begin n_fail++; $display("FAIL flush_word: got %h expected %h", data_out, w); end
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL flush_noop: got %0d expected 0", fill_level); end
        cycle(1, 64'h1, 0, 0); cycle(1, 64'h2, 0, 0); cycle(1, 64'h3, 0, 0); cycle(1, 64'h4, 1, 0);
        n_checks++; if (fill_level !== 5'd1) begin n_fail++; $display("FAIL flush_full_word: got %0d expected 1", fill_level); end
        cycle(0, 0, 0, 1);
        cycle(1, 64'h5, 1, 0);
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 200; i++) begin
            cycle(1, {$urandom, $urandom}, 0, 1);
            n_checks++;
            if (fill_level > 5'd1) begin n_fail++; $display("FAIL stream_fill: got %0d expected <=1", fill_level); end
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) cycle(0, 0, 0, 1);
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_left: got %0d expected 0", exp_q.size()); end
        n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL stream_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] w;
        w = {64'h74, 64'h73, 64'h72, 64'h71};
        for (int i = 0; i < 30; i++) cycle(1, 64'h500 + 64'(i), 0, 0);
        n_checks++; if (fill_level !== 5'd7) begin n_fail++; $display("FAIL mid_pre: got %0d expected 7", fill_level); end
        do_reset();
        n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL mid_empty: got %b expected 1", empty); end
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL mid_fill: got %0d expected 0", fill_level); end
        cycle(1, 64'h71, 0, 0); cycle(1, 64'h72, 0, 0); cycle(1, 64'h73, 0, 0); cycle(1, 64'h74, 0, 0);
        n_checks++; if (data_out !== w) begin n_fail++; $display("FAIL mid_word: got %h expected %h", data_out, w); end
        cycle(0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; flush = 1'b0; rd_en = 1'b0; data_in = '0;
        mcnt = 0; mfill = 0; mstage = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_mux.md
FIFO_MUX -- requirements
Module: fifo_mux

Interface
REQ-001 The block SHALL have parameter DATA_IN_WIDTH, default 64, the narrow write-side beat width.
REQ-002 The block SHALL have parameter DATA_OUT_WIDTH, default 256, the wide read-side word width; RATIO = DATA_OUT_WIDTH/DATA_IN_WIDTH (default 4) must be an integer power of two >= 2.
REQ-003 The block SHALL have parameter DEPTH, default 4; the FIFO holds 2^DEPTH wide words.
REQ-004 The block SHALL have parameter MIN_THER, default 1, the low-water mark in wide words.
REQ-005 The block SHALL have parameter MAX_THER, default 12, the high-water mark in wide words.
REQ-006 The block SHALL have these ports, one clock, reset synchronous and active-high:
 clk  in  1  clock, all state on rising edge
 rst  in  1  synchronous active-high reset
 wr_en  in  1  narrow beat valid; accepted when high and full low
 data_in  in  DATA_IN_WIDTH  narrow beat
 flush  in  1  push the pending partial word, zero-padded
 rd_en  in  1  pop wide head word; ignored when empty
 data_out  out  DATA_OUT_WIDTH  wide head word, first-word-fall-through
 empty  out  1  no wide word available
 full  out  1  FIFO holds 2^DEPTH words; narrow beats refused
 needdata  out  1  fill_level <= MIN_THER
 noneeddata  out  1  fill_level >= MAX_THER
 fill_level  out  DEPTH+1  wide words stored, 0..2^DEPTH; excludes the partial packer word

Function
REQ-007 The packer SHALL hold a lane counter 0..RATIO-1 and a DATA_OUT_WIDTH staging register; an accepted beat goes to lane = counter, lane 0 at bits [DATA_IN_WIDTH-1:0].
REQ-008 On the accepted beat filling lane RATIO-1, the completed word (staging plus this beat) SHALL be written into the FIFO in the same cycle, the counter SHALL return to 0, and the staging register SHALL clear to 0.
REQ-009 A beat SHALL be accepted only when wr_en=1 and full=0; a beat presented while full=1 SHALL be dropped with no state change.
REQ-010 full SHALL be asserted when fill_level = 2^DEPTH, regardless of a same-cycle rd_en; no write-through on full.
REQ-011 flush=1 with counter>0 and full=0 SHALL push the staging word, unwritten lanes zero, and reset the counter to 0; flush with counter=0 SHALL be a no-op.
REQ-012 flush and an accepted beat in the same cycle SHALL include that beat in the pushed word; if it fills lane RATIO-1, exactly one word SHALL be pushed.
REQ-013 The FIFO SHALL be first-word-fall-through: data_out shows the head word whenever empty=0; data_out is don't-care when empty=1.
REQ-014 A pop SHALL occur when rd_en=1 and empty=0; rd_en while empty=1 SHALL be ignored, with no pointer or count change.
REQ-015 A push and a pop in the same cycle SHALL leave fill_level unchanged; a push into an empty FIFO SHALL make empty fall on the next cycle, so write-to-read latency is 1 cycle.
REQ-016 Read and write pointers SHALL be DEPTH bits and wrap modulo 2^DEPTH; fill_level SHALL be a registered up/down counter.
REQ-017 empty, full, needdata and noneeddata SHALL be combinational decodes of registered fill_level, with no glitch-dependent logic.

Reset
REQ-018 With rst=1 at a clock edge: pointers=0, fill_level=0, lane counter=0, staging=0; hence empty=1, full=0, needdata=1, noneeddata=0.
REQ-019 Reset mid-operation SHALL discard all stored words and any partial packer word; wr_en, flush and rd_en in the reset cycle SHALL be ignored.
REQ-020 FIFO storage contents need no reset.

Structure
REQ-021 DATA_IN_WIDTH, DATA_OUT_WIDTH, RATIO and the derived lane-index width SHALL live in the shared spmv kernel package.
REQ-022 The existing Fifo module SHALL be instantiated for storage; the packer SHALL be one sub-module, data_pack, with valid/ready narrow input and a wide valid output.

Verification
REQ-023 Reset, then 4 beats 0x11,0x22,0x33,0x44 -> next cycle empty=0, data_out = {..44,..33,..22,..11} with lane 0 at the LSB, fill_level=1.
REQ-024 Write 64 beats with rd_en=0 (DEPTH=4) -> full=1 after the 16th word, noneeddata=1 from fill_level 12, 65th beat dropped, popped data matches in order.
REQ-025 2 beats 0xA,0xB then flush -> one word {0,0,0xB,0xA}, counter back to 0.
REQ-026 fill_level=16, with rd_en and the 4th beat in the same cycle -> pop occurs, beat dropped, fill_level=15.
REQ-027 Continuous 4-beat writes with rd_en=1 every cycle for 200 cycles -> fill_level stays at 0..1, pointers wrap, no data loss.
REQ-028 rst asserted with fill_level=7 and counter=2 -> next cycle empty=1, fill_level=0, and the next 4 beats form a fresh word starting at lane 0.
